// File: rtl/mmio_periph.sv
// rtl/mmio_periph.sv - single-port MMIO bus slave: wait-stated big-endian data RAM plus GPIO/timer register block
module mmio_periph #(
  parameter int          DM_AW     = 8,
  parameter int          WAIT      = 1,
  parameter int          N_LED     = 16,
  parameter int          N_SW      = 16,
  parameter int          N_PB      = 5,
  parameter logic [11:0] GPIO_BASE = 12'hbf8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [2:0]       dm_op,
  output logic             ack,
  output logic             err,
  output logic [31:0]      rdata,
  output logic [N_LED-1:0] io_led,
  input  logic [N_SW-1:0]  io_switch,
  input  logic [N_PB-1:0]  io_btn,
  input  logic [3:0]       key_val,
  output logic [5:0]       seg_en,
  output logic [23:0]      seg_digits,
  output logic             irq
);

  localparam logic [2:0] DM_OP_WD = 3'd0;
  localparam logic [2:0] DM_OP_BS = 3'd1;
  localparam logic [2:0] DM_OP_BZ = 3'd2;
  localparam logic [2:0] DM_OP_HS = 3'd3;
  localparam logic [2:0] DM_OP_HZ = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]  op_q, op_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [N_LED-1:0] led_q, led_d;
  logic [5:0]       seg_en_q, seg_en_d;
  logic [23:0]      seg_dig_q, seg_dig_d;
  logic [31:0]      timer_q, timer_d, cmp_q, cmp_d;
  logic             pend_q, pend_d;
  logic [N_SW-1:0]  sw_s1_q, sw_s2_q;
  logic [N_PB-1:0]  btn_s1_q, btn_s2_q;
  logic [3:0]       key_s1_q, key_s2_q;

  logic [31:0] mem_q [2**DM_AW];

  // In IDLE the live bus fields describe the transaction; afterwards the latched copy does.
  logic        f_we;
  logic [31:0] f_addr, f_wdata;
  logic [2:0]  f_op;
  logic        is_gpio, is_byte, is_half, acc_err, commit;
  logic        gpio_hit, gpio_ro, gpio_wr, mem_wr;
  logic [7:0]  off;
  logic [31:0] gpio_rval, ram_rd, ram_wr, load_val, byte_v;
  logic [15:0] half_v;
  logic [DM_AW-1:0] idx;
  logic        unused_bits;

  assign unused_bits = ^{f_addr, f_wdata};

  always_comb begin
    f_we    = (state_q == S_IDLE) ? we    : we_q;
    f_addr  = (state_q == S_IDLE) ? addr  : addr_q;
    f_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
    f_op    = (state_q == S_IDLE) ? dm_op : op_q;
    off     = f_addr[7:0];
    idx     = f_addr[DM_AW+1:2];
    is_gpio = (f_addr[31:20] == GPIO_BASE);
    is_byte = (f_op == DM_OP_BS) || (f_op == DM_OP_BZ);
    is_half = (f_op == DM_OP_HS) || (f_op == DM_OP_HZ);

    gpio_hit  = 1'b1;
    gpio_ro   = 1'b0;
    gpio_rval = 32'h0;
    case (off)
      8'h00: gpio_rval = 32'(led_q);
      8'h04: begin gpio_rval = 32'(sw_s2_q);  gpio_ro = 1'b1; end
      8'h08: begin gpio_rval = 32'(btn_s2_q); gpio_ro = 1'b1; end
      8'h0c: gpio_rval = 32'(seg_en_q);
      8'h10: gpio_rval = 32'(seg_dig_q);
      8'h14: begin gpio_rval = 32'(key_s2_q); gpio_ro = 1'b1; end
      8'h18: gpio_rval = timer_q;
      8'h1c: gpio_rval = cmp_q;
      8'h20: gpio_rval = {31'h0, pend_q};
      default: gpio_hit = 1'b0;
    endcase

    if (is_gpio)
      acc_err = (f_addr[1:0] != 2'b00) || !gpio_hit || (f_we && gpio_ro);
    else if (is_half)
      acc_err = f_addr[0];
    else
      acc_err = !is_byte && (f_addr[1:0] != 2'b00);

    // Big-endian lanes: byte offset 0 is the most significant byte of the word.
    ram_rd = mem_q[idx];
    case (f_addr[1:0])
      2'd0:    byte_v = {24'h0, ram_rd[31:24]};
      2'd1:    byte_v = {24'h0, ram_rd[23:16]};
      2'd2:    byte_v = {24'h0, ram_rd[15:8]};
      default: byte_v = {24'h0, ram_rd[7:0]};
    endcase
    half_v = f_addr[1] ? ram_rd[15:0] : ram_rd[31:16];
    case (f_op)
      DM_OP_BS: load_val = {{24{byte_v[7]}}, byte_v[7:0]};
      DM_OP_BZ: load_val = byte_v;
      DM_OP_HS: load_val = {{16{half_v[15]}}, half_v};
      DM_OP_HZ: load_val = {16'h0, half_v};
      default:  load_val = ram_rd;
    endcase

    ram_wr = ram_rd;
    if (is_byte) begin
      case (f_addr[1:0])
        2'd0:    ram_wr[31:24] = f_wdata[7:0];
        2'd1:    ram_wr[23:16] = f_wdata[7:0];
        2'd2:    ram_wr[15:8]  = f_wdata[7:0];
        default: ram_wr[7:0]   = f_wdata[7:0];
      endcase
    end else if (is_half) begin
      if (f_addr[1]) ram_wr[15:0]  = f_wdata[15:0];
      else           ram_wr[31:16] = f_wdata[15:0];
    end else begin
      ram_wr = f_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: if (req) begin
        we_d    = we;
        addr_d  = addr;
        wdata_d = wdata;
        op_d    = dm_op;
        if (is_gpio || acc_err || WAIT == 0) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 3'(WAIT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    commit  = (state_d == S_RESP) && (state_q != S_RESP);
    gpio_wr = commit && is_gpio && !acc_err && f_we;
    mem_wr  = commit && !is_gpio && !acc_err && f_we;

    err_d   = err_q;
    rdata_d = rdata_q;
    if (commit) begin
      err_d = acc_err;
      if (acc_err || f_we) rdata_d = 32'h0;
      else if (is_gpio)    rdata_d = gpio_rval;
      else                 rdata_d = load_val;
    end
  end

  always_comb begin
    led_d     = led_q;
    seg_en_d  = seg_en_q;
    seg_dig_d = seg_dig_q;
    cmp_d     = cmp_q;
    timer_d   = timer_q + 32'd1;
    pend_d    = pend_q;
    if (gpio_wr) begin
      case (off)
        8'h00: led_d     = f_wdata[N_LED-1:0];
        8'h0c: seg_en_d  = f_wdata[5:0];
        8'h10: seg_dig_d = f_wdata[23:0];
        8'h18: timer_d   = f_wdata;
        8'h1c: cmp_d     = f_wdata;
        8'h20: if (f_wdata[0]) pend_d = 1'b0;
        default: ;
      endcase
    end
    // A match in the same cycle as a clear keeps the interrupt pending.
    if (timer_q == cmp_q) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      op_q      <= DM_OP_WD;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      led_q     <= '0;
      seg_en_q  <= 6'h3f;
      seg_dig_q <= 24'h0;
      timer_q   <= 32'h0;
      cmp_q     <= 32'hffff_ffff;
      pend_q    <= 1'b0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      key_s1_q  <= 4'h0;
      key_s2_q  <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      seg_en_q  <= seg_en_d;
      seg_dig_q <= seg_dig_d;
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      pend_q    <= pend_d;
      sw_s1_q   <= io_switch;
      sw_s2_q   <= sw_s1_q;
      btn_s1_q  <= io_btn;
      btn_s2_q  <= btn_s1_q;
      key_s1_q  <= key_val;
      key_s2_q  <= key_s1_q;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[idx] <= ram_wr;
  end

  assign ack        = (state_q == S_RESP);
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign io_led     = led_q;
  assign seg_en     = seg_en_q;
  assign seg_digits = seg_dig_q;
  assign irq        = pend_q;

endmodule

// File: tb/tb_mmio_periph.sv
// tb/tb_mmio_periph.sv - directed scoreboard bench for mmio_periph with WAIT=2
module tb_mmio_periph;

  localparam logic [2:0] OP_WD = 3'd0;
  localparam logic [2:0] OP_BS = 3'd1;
  localparam logic [2:0] OP_BZ = 3'd2;
  localparam logic [2:0] OP_HS = 3'd3;
  localparam logic [2:0] OP_HZ = 3'd4;
  localparam logic [31:0] GP = 32'hbf80_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [2:0]  dm_op;
  logic        ack, err;
  logic [31:0] rdata;
  logic [15:0] io_led;
  logic [15:0] io_switch;
  logic [4:0]  io_btn;
  logic [3:0]  key_val;
  logic [5:0]  seg_en;
  logic [23:0] seg_digits;
  logic        irq;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mmio_periph #(.DM_AW(8), .WAIT(2), .N_LED(16), .N_SW(16), .N_PB(5), .GPIO_BASE(12'hbf8)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .dm_op(dm_op),
    .ack(ack), .err(err), .rdata(rdata), .io_led(io_led), .io_switch(io_switch),
    .io_btn(io_btn), .key_val(key_val), .seg_en(seg_en), .seg_digits(seg_digits), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] op, input logic e_err, input logic [31:0] e_rd, input int e_lat);
    exp_t ex;
    int   lat;
    @(negedge clk);
    chk({tag, "_gap"}, 32'(ack), 32'h0);
    ex.err = e_err; ex.rdata = e_rd; ex.lat = e_lat;
    sb.push_back(ex);
    req = 1'b1; we = w; addr = a; wdata = d; dm_op = op;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; dm_op = OP_WD;
    lat = 1;
    while (ack !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_ack"}, 32'(ack), 32'h1);
    ex = sb.pop_front();
    chk({tag, "_lat"}, 32'(lat), 32'(ex.lat));
    chk({tag, "_err"}, 32'(err), 32'(ex.err));
    chk({tag, "_rdata"}, rdata, ex.rdata);
  endtask

  initial begin
    int n;
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; dm_op = OP_WD;
    io_switch = 16'h0; io_btn = 5'h0; key_val = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_led", 32'(io_led), 32'h0);
    chk("rst_seg_en", 32'(seg_en), 32'h3f);
    chk("rst_seg_dig", 32'(seg_digits), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst = 1'b1;

    do_txn("sw40", 1'b1, 32'h40, 32'h1234_5678, OP_WD, 1'b0, 32'h0, 3);
    do_txn("lw40", 1'b0, 32'h40, 32'h0, OP_WD, 1'b0, 32'h1234_5678, 3);
    do_txn("lw_alias", 1'b0, 32'h440, 32'h0, OP_WD, 1'b0, 32'h1234_5678, 3);

    do_txn("sw80", 1'b1, 32'h80, 32'haabb_ccdd, OP_WD, 1'b0, 32'h0, 3);
    do_txn("sb82", 1'b1, 32'h82, 32'h0000_0011, OP_BZ, 1'b0, 32'h0, 3);
    do_txn("lw80", 1'b0, 32'h80, 32'h0, OP_WD, 1'b0, 32'haabb_11dd, 3);
    do_txn("lb80", 1'b0, 32'h80, 32'h0, OP_BS, 1'b0, 32'hffff_ffaa, 3);
    do_txn("lbu80", 1'b0, 32'h80, 32'h0, OP_BZ, 1'b0, 32'h0000_00aa, 3);
    do_txn("lh82", 1'b0, 32'h82, 32'h0, OP_HS, 1'b0, 32'h0000_11dd, 3);
    do_txn("lhu80", 1'b0, 32'h80, 32'h0, OP_HZ, 1'b0, 32'h0000_aabb, 3);
    do_txn("sh80", 1'b1, 32'h80, 32'h0000_8001, OP_HS, 1'b0, 32'h0, 3);
    do_txn("lh80", 1'b0, 32'h80, 32'h0, OP_HS, 1'b0, 32'hffff_8001, 3);

    do_txn("lw81_mis", 1'b0, 32'h81, 32'h0, OP_WD, 1'b1, 32'h0, 1);
    do_txn("lh83_mis", 1'b0, 32'h83, 32'h0, OP_HZ, 1'b1, 32'h0, 1);
    do_txn("sh81_mis", 1'b1, 32'h81, 32'h0000_ffff, OP_HZ, 1'b1, 32'h0, 1);
    do_txn("sw_ro_sw", 1'b1, GP | 32'h04, 32'hffff_ffff, OP_WD, 1'b1, 32'h0, 1);
    do_txn("lw80_kept", 1'b0, 32'h80, 32'h0, OP_WD, 1'b0, 32'h8001_11dd, 3);
    do_txn("gp_unmap", 1'b0, GP | 32'h24, 32'h0, OP_WD, 1'b1, 32'h0, 1);
    do_txn("gp_mis", 1'b0, GP | 32'h02, 32'h0, OP_BZ, 1'b1, 32'h0, 1);

    io_switch = 16'h00a5;
    repeat (2) @(negedge clk);
    do_txn("rd_sw", 1'b0, GP | 32'h04, 32'h0, OP_BS, 1'b0, 32'h0000_00a5, 1);
    do_txn("wr_led", 1'b1, GP | 32'h00, 32'h0000_ffff, OP_WD, 1'b0, 32'h0, 1);
    chk("io_led", 32'(io_led), 32'h0000_ffff);
    do_txn("wr_seg_en", 1'b1, GP | 32'h0c, 32'hffff_ff05, OP_WD, 1'b0, 32'h0, 1);
    chk("seg_en", 32'(seg_en), 32'h05);
    do_txn("rd_seg_en", 1'b0, GP | 32'h0c, 32'h0, OP_WD, 1'b0, 32'h0000_0005, 1);

    do_txn("wr_cmp", 1'b1, GP | 32'h1c, 32'h20, OP_WD, 1'b0, 32'h0, 1);
    do_txn("clr_irq0", 1'b1, GP | 32'h20, 32'h1, OP_WD, 1'b0, 32'h0, 1);
    do_txn("wr_timer", 1'b1, GP | 32'h18, 32'h10, OP_WD, 1'b0, 32'h0, 1);
    chk("irq_low", 32'(irq), 32'h0);
    n = 0;
    while (irq !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("irq_rise_cycles", 32'(n), 32'd17);
    do_txn("rd_irq_stat", 1'b0, GP | 32'h20, 32'h0, OP_WD, 1'b0, 32'h1, 1);
    do_txn("clr_irq", 1'b1, GP | 32'h20, 32'h1, OP_WD, 1'b0, 32'h0, 1);
    chk("irq_cleared", 32'(irq), 32'h0);

    do_txn("sw100", 1'b1, 32'h100, 32'h1111_1111, OP_WD, 1'b0, 32'h0, 3);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h100; wdata = 32'hdead_beef; dm_op = OP_WD;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_ack", 32'(ack), 32'h0);
      @(negedge clk);
    end
    chk("abort_led_rst", 32'(io_led), 32'h0);
    chk("abort_seg_en_rst", 32'(seg_en), 32'h3f);
    do_txn("lw100_kept", 1'b0, 32'h100, 32'h0, OP_WD, 1'b0, 32'h1111_1111, 3);
    do_txn("lw40_kept", 1'b0, 32'h40, 32'h0, OP_WD, 1'b0, 32'h1234_5678, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_periph.md
MMIO_PERIPH -- requirements
Module: mmio_periph

Interface
REQ-001 Parameter DM_AW, 8, data-RAM word-address bits; depth = 2**DM_AW words of 32 bits.
REQ-002 Parameter WAIT, 1, RAM wait states (0..7) inserted before ack.
REQ-003 Parameter N_LED, 16, LED output width.
REQ-004 Parameter N_SW, 16, switch input width.
REQ-005 Parameter N_PB, 5, push-button input width.
REQ-006 Parameter GPIO_BASE, 12'hbf8, addr[31:20] value selecting GPIO space; all other values select RAM.
REQ-007 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-008 Port clk  in  1  system clock, all state on rising edge.
REQ-009 Port rst  in  1  asynchronous active-low reset.
REQ-010 Ports req in 1 request; we in 1 write; addr in 32; wdata in 32; dm_op in 3, DM_OP_* encoding from common.v.
REQ-011 Ports ack out 1 one-cycle completion pulse; err out 1 error, valid with ack; rdata out 32 load data, valid with ack.
REQ-012 Ports io_led out N_LED; io_switch in N_SW; io_btn in N_PB; key_val in 4 keypad code.
REQ-013 Ports seg_en out 6 digit enables; seg_digits out 24 digit data; irq out 1 level timer interrupt.

Function
REQ-014 FSM states IDLE, WAIT, RESP; in IDLE with req=1, fields are sampled; GPIO/error access goes to RESP, RAM access goes to WAIT (WAIT>0) or RESP (WAIT=0).
REQ-015 WAIT counts WAIT cycles then enters RESP; RESP asserts ack for exactly one cycle and returns to IDLE; ack is never asserted back-to-back.
REQ-016 Latency: ack appears 1 cycle after acceptance for GPIO/error, 1+WAIT cycles for RAM.
REQ-017 Request fields are latched at acceptance; req dropping before ack does not cancel; transaction completes and acks.
REQ-018 Writes commit on the edge entering RESP; rdata/err update on that edge and hold until the next ack.
REQ-019 Byte lanes are big-endian: addr[1:0]=0 selects bits 31:24, 3 selects 7:0; halfword addr[1]=0 selects 31:16.
REQ-020 SB/SH write only the addressed lane(s); other lanes of the word are unchanged.
REQ-021 BS/BZ/HS/HZ extract the addressed lane and sign/zero-extend to 32 bits; WD returns the whole word.
REQ-022 Misaligned access (halfword addr[0]=1, word or any GPIO access addr[1:0]!=0) gives err=1, rdata=0, no state change.
REQ-023 RAM index is addr[DM_AW+1:2]; higher address bits are ignored (aliasing).
REQ-024 GPIO map on addr[7:0]: 00 LED RW; 04 SW RO; 08 BTN RO; 0C SEG_EN RW; 10 SEG_DIGITS RW; 14 KEYPAD RO; 18 TIMER RW; 1C COMPARE RW; 20 IRQ_STAT R bit0, write bit0=1 clears.
REQ-025 GPIO reads zero-extend; writes truncate to register width; dm_op is ignored in GPIO space.
REQ-026 Write to RO offset or access to unmapped offset gives err=1, rdata=0, no side effect.
REQ-027 io_switch, io_btn, key_val pass through 2-flop synchronizers; reads return synchronized values.
REQ-028 TIMER is 32-bit, increments every cycle, wraps FFFFFFFF->0; a bus write loads wdata and takes priority over increment.
REQ-029 IRQ pending sets on any cycle TIMER register equals COMPARE; set wins over simultaneous clear; irq = pending.

Reset
REQ-030 On rst=0: FSM IDLE, ack=0, err=0, rdata=0, io_led=0, seg_en=6'h3F, seg_digits=0, TIMER=0, COMPARE=FFFFFFFF, irq=0, synchronizers 0.
REQ-031 Reset mid-transaction aborts it: no ack, uncommitted write dropped; RAM contents are not reset.

Verification
REQ-032 WAIT=2: SW 0x12345678 to RAM 0x40, then LW 0x40 -> each ack 3 cycles after acceptance, rdata=12345678, err=0.
REQ-033 Word AABBCCDD at 0x80; SB 0x11 at 0x82 -> word AABB11DD; LB 0x80 -> FFFFFFAA; LBU 0x80 -> 000000AA; LH 0x82 -> 000011DD.
REQ-034 LW 0x81 and SW to 0xBF800004 -> err=1, rdata=0, RAM/registers unchanged, ack after 1 cycle.
REQ-035 Write COMPARE=0x20, TIMER=0x10 -> irq rises when TIMER equals 0x20; write IRQ_STAT=1 -> irq=0 next cycle.
REQ-036 io_switch=0x00A5 -> read 0xBF800004 returns 0x000000A5 two cycles later; write LED 0xFFFF -> io_led=FFFF; assert rst during RAM WAIT -> no ack, write absent.
